// File: rtl/note_voice_alloc_if.sv
// Note event handshake bus: a decoded MIDI note-on/off offered with valid/ready.
interface note_voice_alloc_if;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_on;
  logic [7:0] ev_key;
  logic [7:0] ev_vel;

  modport master (output ev_valid, output ev_on, output ev_key, output ev_vel, input ev_ready);
  modport slave  (input ev_valid, input ev_on, input ev_key, input ev_vel, output ev_ready);
endinterface

// File: rtl/note_voice_alloc.sv
// Voice allocator: buffers note events, assigns/releases voices and presents
// each note-on long enough for a frame-boundary capture in the audio domain.
module note_voice_alloc #(
  parameter int VOICES     = 8,
  parameter int V_WIDTH    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               AUDIO_CLK,
  input  logic               reset_reg_N,
  input  logic               xxxx_zero,
  note_voice_alloc_if.slave  ev,
  output logic               note_on,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [VOICES-1:0]  keys_on,
  output logic               steal
);
  localparam int A_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, SEARCH, COMMIT, HOLD, GAP} state_t;
  state_t state, state_nxt;

  logic [16:0]        fifo_mem [FIFO_DEPTH];
  logic [A_W-1:0]     wr_ptr, rd_ptr;
  logic [A_W:0]       fifo_cnt;
  logic               push, pop, fifo_empty;

  logic               zero_q, fe;
  logic               w_on;
  logic [7:0]         w_key, w_vel;
  logic [V_WIDTH-1:0] idx, match_idx, free_idx, steal_ptr, tgt;
  logic               match_found, free_found, hit, fe_once;
  logic [7:0]         voice_key [VOICES];

  assign ev.ev_ready = (fifo_cnt != (A_W+1)'(FIFO_DEPTH));
  assign fifo_empty  = (fifo_cnt == '0);
  assign push        = ev.ev_valid && ev.ev_ready;
  assign fe          = zero_q && !xxxx_zero;
  assign hit         = keys_on[idx] && (voice_key[idx] == w_key);

  always_ff @(posedge AUDIO_CLK) begin
    if (push) fifo_mem[wr_ptr] <= {ev.ev_on, ev.ev_key, ev.ev_vel};
  end

  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + A_W'(1);
      if (pop)  rd_ptr <= rd_ptr + A_W'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + (A_W+1)'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - (A_W+1)'(1);
    end
  end

  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:    if (!fifo_empty) begin
                 pop       = 1'b1;
                 state_nxt = SEARCH;
               end
      SEARCH:  if (idx == V_WIDTH'(VOICES-1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = w_on ? HOLD : IDLE;
      HOLD:    if (fe && fe_once) state_nxt = GAP;
      GAP:     if (fe) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Retrigger beats free voice, free voice beats round-robin steal.
  always_comb begin
    if (match_found)     tgt = match_idx;
    else if (free_found) tgt = free_idx;
    else                 tgt = steal_ptr;
  end

  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      zero_q      <= 1'b0;
      note_on     <= 1'b0;
      cur_key_adr <= '0;
      cur_key_val <= '0;
      cur_vel_on  <= '0;
      keys_on     <= '0;
      steal       <= 1'b0;
      steal_ptr   <= '0;
      w_on        <= 1'b0;
      w_key       <= '0;
      w_vel       <= '0;
      idx         <= '0;
      match_idx   <= '0;
      free_idx    <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      fe_once     <= 1'b0;
      for (int unsigned i = 0; i < VOICES; i++) voice_key[i] <= '0;
    end else begin
      zero_q <= xxxx_zero;
      steal  <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) {w_on, w_key, w_vel} <= fifo_mem[rd_ptr];
          idx         <= '0;
          match_found <= 1'b0;
          free_found  <= 1'b0;
        end
        SEARCH: begin
          if (hit && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= idx;
          end
          if (!keys_on[idx] && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          idx <= idx + V_WIDTH'(1);
        end
        COMMIT: begin
          if (w_on) begin
            voice_key[tgt] <= w_key;
            keys_on[tgt]   <= 1'b1;
            cur_key_adr    <= tgt;
            cur_key_val    <= w_key;
            cur_vel_on     <= w_vel;
            note_on        <= 1'b1;
            fe_once        <= 1'b0;
            if (!match_found && !free_found) begin
              steal     <= 1'b1;
              steal_ptr <= (steal_ptr == V_WIDTH'(VOICES-1)) ? '0 : steal_ptr + V_WIDTH'(1);
            end
          end else if (match_found) begin
            keys_on[match_idx] <= 1'b0;
            cur_key_adr        <= match_idx;
          end
        end
        HOLD: begin
          if (fe) begin
            if (fe_once) note_on <= 1'b0;
            else         fe_once <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_note_voice_alloc.sv
// Scoreboard bench for note_voice_alloc: a voice-table model queues expected
// commits at event acceptance; a monitor matches them against DUT outputs.
module tb_note_voice_alloc;
  localparam int VOICES = 8;

  logic              AUDIO_CLK = 1'b0;
  logic              reset_reg_N;
  logic              xxxx_zero;
  logic              note_on, steal;
  logic [2:0]        cur_key_adr;
  logic [7:0]        cur_key_val, cur_vel_on;
  logic [VOICES-1:0] keys_on;

  note_voice_alloc_if ev ();

  note_voice_alloc #(.VOICES(8), .V_WIDTH(3), .FIFO_DEPTH(4)) dut (
    .AUDIO_CLK   (AUDIO_CLK),
    .reset_reg_N (reset_reg_N),
    .xxxx_zero   (xxxx_zero),
    .ev          (ev),
    .note_on     (note_on),
    .cur_key_adr (cur_key_adr),
    .cur_key_val (cur_key_val),
    .cur_vel_on  (cur_vel_on),
    .keys_on     (keys_on),
    .steal       (steal)
  );

  always #5 AUDIO_CLK = ~AUDIO_CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: voice table updated in acceptance order.
  typedef struct {
    bit on;
    int adr;
    int key;
    int vel;
    int keys;
    bit stl;
  } exp_t;

  exp_t              sb[$];
  logic [7:0]        m_vk [VOICES];
  logic [VOICES-1:0] m_on;
  int                m_sp, m_last_key, m_last_vel;

  function automatic void model_reset();
    for (int i = 0; i < VOICES; i++) m_vk[i] = 8'd0;
    m_on = '0;
    m_sp = 0;
    m_last_key = 0;
    m_last_vel = 0;
    sb.delete();
  endfunction

  function automatic void model_event(input bit on, input int key, input int vel);
    int   m = -1;
    int   f = -1;
    int   t;
    exp_t e;
    for (int i = 0; i < VOICES; i++) begin
      if (m < 0 && m_on[i] && int'(m_vk[i]) == key) m = i;
      if (f < 0 && !m_on[i]) f = i;
    end
    if (on) begin
      e.stl = (m < 0 && f < 0);
      t = (m >= 0) ? m : ((f >= 0) ? f : m_sp);
      if (e.stl) m_sp = (m_sp + 1) % VOICES;
      m_vk[t] = key[7:0];
      m_on[t] = 1'b1;
      m_last_key = key;
      m_last_vel = vel;
      e.on = 1; e.adr = t; e.key = key; e.vel = vel; e.keys = int'(m_on);
      sb.push_back(e);
    end else if (m >= 0) begin
      m_on[m] = 1'b0;
      e.on = 0; e.adr = m; e.key = m_last_key; e.vel = m_last_vel; e.keys = int'(m_on); e.stl = 0;
      sb.push_back(e);
    end
  endfunction

  // Frame marker: one-cycle high pulse every 3..7 cycles when enabled.
  bit frames_on = 0;
  initial begin
    int cnt = 0;
    int period = 4;
    xxxx_zero = 1'b0;
    forever begin
      @(posedge AUDIO_CLK);
      #1;
      if (frames_on) begin
        cnt++;
        if (cnt >= period) begin
          xxxx_zero = 1'b1;
          cnt = 0;
          period = $urandom_range(3, 7);
        end else begin
          xxxx_zero = 1'b0;
        end
      end else begin
        xxxx_zero = 1'b0;
      end
    end
  end

  // Frame edge as the DUT sees it at each rising clock edge.
  logic zq, fe_seen;
  always @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      zq      <= 1'b0;
      fe_seen <= 1'b0;
    end else begin
      fe_seen <= zq && !xxxx_zero;
      zq      <= xxxx_zero;
    end
  end

  // Monitor: note_on rise = note-on commit, keys_on change otherwise = note-off commit.
  initial begin
    logic              p_note = 1'b0;
    logic [VOICES-1:0] p_keys = '0;
    int                hold_cnt = 0;
    int                gap_fe = 0;
    bit                had_fall = 0;
    bit                rise;
    exp_t              e;
    forever begin
      @(negedge AUDIO_CLK);
      if (!reset_reg_N) begin
        p_note = 1'b0; p_keys = '0; hold_cnt = 0; gap_fe = 0; had_fall = 0;
      end else begin
        rise = note_on && !p_note;
        if (rise) begin
          if (sb.size() == 0) begin
            chk("unexpected_note_on", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("commit_kind_on", 32'd1, 32'(e.on));
            chk("on_cur_key_adr", 32'(cur_key_adr), 32'(e.adr));
            chk("on_cur_key_val", 32'(cur_key_val), 32'(e.key));
            chk("on_cur_vel_on", 32'(cur_vel_on), 32'(e.vel));
            chk("on_keys_on", 32'(keys_on), 32'(e.keys));
            chk("on_steal", 32'(steal), 32'(e.stl));
          end
          if (had_fall) chk("gap_frame_before_note_on", 32'(gap_fe >= 1), 32'd1);
          hold_cnt = 0;
        end else begin
          if (steal) chk("steal_without_note_on", 32'(steal), 32'd0);
          if (p_note) begin
            if (fe_seen) hold_cnt++;
            chk("note_on_hold", 32'(note_on), 32'(hold_cnt < 2));
            if (!note_on) begin
              had_fall = 1;
              gap_fe = 0;
            end
          end else begin
            if (fe_seen) gap_fe++;
            if (keys_on != p_keys) begin
              if (sb.size() == 0) begin
                chk("unexpected_keys_change", 32'(keys_on), 32'(p_keys));
              end else begin
                e = sb.pop_front();
                chk("commit_kind_off", 32'd0, 32'(e.on));
                chk("off_cur_key_adr", 32'(cur_key_adr), 32'(e.adr));
                chk("off_keys_on", 32'(keys_on), 32'(e.keys));
                chk("off_cur_key_val", 32'(cur_key_val), 32'(e.key));
                chk("off_cur_vel_on", 32'(cur_vel_on), 32'(e.vel));
                chk("off_note_on", 32'(note_on), 32'd0);
              end
            end
          end
        end
        p_note = note_on;
        p_keys = keys_on;
      end
    end
  end

  // Called at a falling edge; returns at a falling edge with ev_valid low.
  task automatic send(input bit on, input int key, input int vel);
    int n = 0;
    ev.ev_valid = 1'b1;
    ev.ev_on    = on;
    ev.ev_key   = key[7:0];
    ev.ev_vel   = vel[7:0];
    while (!ev.ev_ready && n < 3000) begin
      @(negedge AUDIO_CLK);
      n++;
    end
    if (!ev.ev_ready) begin
      chk("send_timeout", 32'd1, 32'd0);
      ev.ev_valid = 1'b0;
    end else begin
      @(posedge AUDIO_CLK);
      model_event(on, key, vel);
      @(negedge AUDIO_CLK);
      ev.ev_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(negedge AUDIO_CLK);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (40) @(negedge AUDIO_CLK);
  endtask

  initial begin
    int n;
    int k;
    ev.ev_valid = 1'b0;
    ev.ev_on    = 1'b0;
    ev.ev_key   = 8'd0;
    ev.ev_vel   = 8'd0;
    reset_reg_N = 1'b0;
    model_reset();
    repeat (3) @(negedge AUDIO_CLK);
    chk("rst_note_on", 32'(note_on), 32'd0);
    chk("rst_cur_key_adr", 32'(cur_key_adr), 32'd0);
    chk("rst_cur_key_val", 32'(cur_key_val), 32'd0);
    chk("rst_cur_vel_on", 32'(cur_vel_on), 32'd0);
    chk("rst_keys_on", 32'(keys_on), 32'd0);
    chk("rst_steal", 32'(steal), 32'd0);
    chk("rst_ev_ready", 32'(ev.ev_ready), 32'd1);
    reset_reg_N = 1'b1;
    frames_on = 1;
    @(negedge AUDIO_CLK);

    // First note-on: 10 cycles from acceptance edge to note_on.
    send(1, 60, 100);
    n = 0;
    while (!note_on && n < 50) begin
      @(negedge AUDIO_CLK);
      n++;
    end
    chk("note_on_latency", 32'(n), 32'd10);
    drain();

    send(0, 60, 0);
    send(0, 99, 0);
    drain();

    // Fill all voices, then two steals.
    for (int i = 0; i < 8; i++) send(1, 60 + i, 10 + i);
    send(1, 70, 77);
    send(1, 71, 78);
    drain();
    chk("all_voices_on", 32'(keys_on), 32'hFF);

    // Retrigger of a sounding key.
    send(1, 64, 50);
    send(1, 64, 90);
    drain();
    for (int i = 0; i < 8; i++) begin
      k = (i == 0) ? 70 : ((i == 1) ? 71 : 60 + i);
      send(0, k, 0);
    end
    drain();
    chk("all_voices_released", 32'(keys_on), 32'd0);

    // Burst with frames stopped: one in flight plus four buffered fills the FIFO.
    frames_on = 0;
    for (int i = 0; i < 5; i++) send(1, 40 + i, 20 + i);
    repeat (3) @(negedge AUDIO_CLK);
    chk("fifo_full_ev_ready", 32'(ev.ev_ready), 32'd0);
    frames_on = 1;
    send(1, 45, 25);
    drain();

    // Randomized mix over a narrow key range to exercise matches and steals.
    for (int i = 0; i < 40; i++) begin
      send($urandom_range(0, 2) != 0, $urandom_range(60, 71), $urandom_range(1, 127));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(negedge AUDIO_CLK);
    end
    drain();

    // Asynchronous reset while a note is held.
    send(1, 50, 60);
    n = 0;
    while (!note_on && n < 200) begin
      @(negedge AUDIO_CLK);
      n++;
    end
    chk("note_on_before_reset", 32'(note_on), 32'd1);
    repeat (2) @(negedge AUDIO_CLK);
    #2;
    reset_reg_N = 1'b0;
    #1;
    chk("async_rst_note_on", 32'(note_on), 32'd0);
    chk("async_rst_keys_on", 32'(keys_on), 32'd0);
    model_reset();
    repeat (3) @(negedge AUDIO_CLK);
    reset_reg_N = 1'b1;
    #1;
    chk("post_rst_ev_ready", 32'(ev.ev_ready), 32'd1);
    @(negedge AUDIO_CLK);
    send(1, 52, 33);
    drain();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/note_voice_alloc.md
# note_voice_alloc

Voice allocator and event transmitter feeding the audio-domain note/key/velocity synchronizer. It accepts decoded MIDI note-on/note-off events through a valid/ready handshake and buffers them in a small FIFO. For each event it assigns or releases a voice (free-voice search, retrigger, round-robin steal). It then drives note_on, cur_key_adr, cur_key_val, cur_vel_on and keys_on, holding each note-on long enough for the frame-boundary capture on the receiving side to latch it.

## Interface
- VOICES, 8, number of voices
- V_WIDTH, 3, voice index width (clog2 VOICES)
- FIFO_DEPTH, 4, event FIFO entries (power of 2)

- AUDIO_CLK  in  1  single clock; all logic on rising edge
- reset_reg_N  in  1  asynchronous, active-low reset
- xxxx_zero  in  1  frame marker, synchronous to AUDIO_CLK; its falling edge is the receiver's capture point
- ev_valid  in  1  event present
- ev_ready  out  1  FIFO not full; event accepted on ev_valid && ev_ready
- ev_on  in  1  1 = note-on, 0 = note-off
- ev_key  in  8  MIDI key number
- ev_vel  in  8  velocity (ignored for note-off)
- note_on  out  1  level; high while a new note-on is presented
- cur_key_adr  out  V_WIDTH  voice index of last committed event
- cur_key_val  out  8  key of last committed note-on
- cur_vel_on  out  8  velocity of last committed note-on
- keys_on  out  VOICES  per-voice gate bitmask
- steal  out  1  one-cycle pulse when a note-on stole a voice

## Operation
- Reset: note_on=0, cur_key_adr=0, cur_key_val=0, cur_vel_on=0, keys_on=0, steal=0, FIFO empty, ev_ready=1, steal_ptr=0, voice_key table=0, state IDLE.
- Frame edge detect: xxxx_zero registered once. fe = prev && !xxxx_zero.
- FIFO: push on ev_valid&&ev_ready. ev_ready = !full. Simultaneous push and pop is legal when not full. A push while full cannot occur.
- IDLE: if FIFO not empty, pop the head into the working registers and go to SEARCH with idx=0.
- SEARCH (VOICES cycles, one voice per cycle): record the first match (keys_on[i] && voice_key[i]==key) and the first free voice (!keys_on[i]). After idx=VOICES-1, go to COMMIT.
- COMMIT, note-on:
  - target = match if found; otherwise first free; otherwise steal_ptr, with steal_ptr+1 (mod VOICES) and steal pulse.
  - voice_key[target]=key; keys_on[target]=1; cur_key_adr=target; cur_key_val=key; cur_vel_on=vel; note_on=1.
  - Next state HOLD, with edge count cleared.
- COMMIT, note-off:
  - With a match: keys_on[match]=0, cur_key_adr=match. cur_key_val, cur_vel_on and note_on are unchanged.
  - Without a match: no output change.
  - Next state IDLE.
- HOLD: count fe. On the 2nd fe, note_on=0 and go to GAP.
- GAP: on the next fe, go to IDLE. This guarantees the receiver sees note_on low for one frame before the next note-on.
- Retrigger of a sounding key reuses its voice. keys_on stays 1 and no steal occurs.
- cur_* outputs change only in COMMIT and are otherwise stable.

## Timing
- All outputs are registered. A COMMIT in cycle t is visible at t+1.
- Latency from pop (IDLE cycle) to note_on high: VOICES+2 cycles (1 IDLE + VOICES SEARCH + 1 COMMIT); 10 cycles at default.
- An fe in the same cycle as COMMIT is not counted. Counting starts the cycle after note_on rises.
- note_on high duration: from COMMIT+1 through the cycle of the 2nd counted fe.
- Minimum spacing between consecutive note_on rising edges: 3 frame edges.
- Note-off throughput: one per VOICES+2 cycles. No frame wait.
- Asynchronous reset asserted mid-HOLD or mid-SEARCH clears everything immediately, including dropping note_on and flushing the FIFO.

## Test plan
- Reset, then note-on key 60 vel 100 -> after 10 cycles note_on=1, cur_key_adr=0, cur_key_val=60, cur_vel_on=100, keys_on=8'h01. note_on falls on the 2nd fe.
- Eight note-ons with keys 60..67 -> keys_on=8'hFF, voices 0..7 in order. A 9th note-on, key 70, -> steal pulse, cur_key_adr=0, voice_key[0]=70. A 10th note-on steals voice 1.
- Note-on 60, then note-off 60 -> keys_on returns to 0, cur_key_adr=0, note_on unaffected. Note-off for unknown key 99 -> no output change.
- Retrigger: note-on 64 vel 50, then note-on 64 vel 90 -> same cur_key_adr, cur_vel_on=90, no steal, keys_on unchanged.
- Burst of 6 events with no fe activity -> ev_ready=0 after the FIFO holds 4 events while one is in progress. No event is lost. All are committed in order once frames run.
- Reset asserted while in HOLD with note_on=1 -> note_on=0 and keys_on=0 asynchronously, ev_ready=1 on release.
